// File: rtl/internal_cell_pipe.sv
// Systolic internal cell: multiply-accumulate against a stored element p, with
// neighbour pivoting, a load/unload shift path and a clear path. The latency is
// selectable as 1 or 2 cycles, and p always updates on the accepting edge so
// that back-to-back beats never stall.
module internal_cell_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FRAC_W = 16,
    parameter int unsigned PIPE   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] c_in,
    input  logic [DATA_W-1:0] x_in,
    input  logic              s_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] c_out,
    output logic [DATA_W-1:0] x_out,
    output logic              s_out,
    output logic              ovf,
    output logic              ovf_sticky,
    output logic [DATA_W-1:0] p_out
);

    typedef enum logic [1:0] {
        ModeNonPiv = 2'b00,
        ModePiv    = 2'b01,
        ModeShift  = 2'b10,
        ModeClear  = 2'b11
    } mode_e;

    localparam int unsigned PW = 2 * DATA_W;
    localparam int unsigned SW = 2 * DATA_W + 1;

    localparam logic signed [SW-1:0] SatMax = $signed({{(DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}});
    localparam logic signed [SW-1:0] SatMin = $signed({{(DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}});

    mode_e                    mode_dec;
    logic [DATA_W-1:0]        p_q, p_d;
    logic                     sw;
    logic signed [DATA_W-1:0] w1, w2;
    logic signed [PW-1:0]     prod, prod_sh;
    logic                     byp;
    logic signed [PW-1:0]     s0_prod;
    logic signed [DATA_W-1:0] s0_add;

    // Signals entering the final saturate-and-register stage
    logic                     fin_valid;
    logic                     fin_byp;
    logic                     fin_s;
    logic [DATA_W-1:0]        fin_c;
    logic signed [PW-1:0]     fin_prod;
    logic signed [DATA_W-1:0] fin_add;

    logic signed [SW-1:0]     sum;
    logic                     sat_hi, sat_lo;
    logic [DATA_W-1:0]        sat_res;
    logic                     ovf_d;

    logic                     out_valid_q, s_out_q, ovf_q, ovf_sticky_q;
    logic [DATA_W-1:0]        c_out_q, x_out_q;

    assign mode_dec = mode_e'(mode);

    // Operand selection, product and next value of p
    always_comb begin
        sw      = (mode_dec == ModePiv) && s_in;
        w1      = sw ? $signed(x_in) : $signed(p_q);
        w2      = sw ? $signed(p_q) : $signed(x_in);
        prod    = $signed(c_in) * w1;
        prod_sh = prod >>> FRAC_W;
        // Shift and clear bypass the multiplier: product forced to 0 so the adder passes the
        // bypass value through unchanged and can never saturate.
        byp     = mode[1];
        s0_prod = byp ? '0 : prod_sh;
        if (mode_dec == ModeShift) begin
            s0_add = $signed(p_q);
        end else if (mode_dec == ModeClear) begin
            s0_add = $signed(x_in);
        end else begin
            s0_add = w2;
        end
        p_d = p_q;
        if (in_valid) begin
            unique case (mode_dec)
                ModeNonPiv, ModePiv: p_d = sw ? x_in : p_q;
                ModeShift:           p_d = x_in;
                ModeClear:           p_d = '0;
                default:             p_d = p_q;
            endcase
        end
    end

    // Stored element
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    if (PIPE == 1) begin : g_pipe1
        assign fin_valid = in_valid;
        assign fin_byp   = byp;
        assign fin_s     = s_in;
        assign fin_c     = c_in;
        assign fin_prod  = s0_prod;
        assign fin_add   = s0_add;
    end else begin : g_pipe2
        logic                     s1_valid, s1_byp, s1_s;
        logic [DATA_W-1:0]        s1_c;
        logic signed [PW-1:0]     s1_prod;
        logic signed [DATA_W-1:0] s1_add;

        // Stage 1: shifted product, addend and side-band of the beat
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_valid <= 1'b0;
                s1_byp   <= 1'b0;
                s1_s     <= 1'b0;
                s1_c     <= '0;
                s1_prod  <= '0;
                s1_add   <= '0;
            end else begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_byp  <= byp;
                    s1_s    <= s_in;
                    s1_c    <= c_in;
                    s1_prod <= s0_prod;
                    s1_add  <= s0_add;
                end
            end
        end

        assign fin_valid = s1_valid;
        assign fin_byp   = s1_byp;
        assign fin_s     = s1_s;
        assign fin_c     = s1_c;
        assign fin_prod  = s1_prod;
        assign fin_add   = s1_add;
    end

    // Wide sum and clamp to the signed DATA_W range
    always_comb begin
        sum     = $signed({fin_prod[PW-1], fin_prod})
                + $signed({{(DATA_W + 1){fin_add[DATA_W-1]}}, fin_add});
        sat_hi  = sum > SatMax;
        sat_lo  = sum < SatMin;
        sat_res = sum[DATA_W-1:0];
        if (sat_hi) begin
            sat_res = SatMax[DATA_W-1:0];
        end else if (sat_lo) begin
            sat_res = SatMin[DATA_W-1:0];
        end
        ovf_d = fin_valid && !fin_byp && (sat_hi || sat_lo);
    end

    // Output stage: data holds between beats, qualifiers pulse per beat
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            ovf_q        <= 1'b0;
            ovf_sticky_q <= 1'b0;
            x_out_q      <= '0;
            c_out_q      <= '0;
            s_out_q      <= 1'b0;
        end else begin
            out_valid_q  <= fin_valid;
            ovf_q        <= ovf_d;
            ovf_sticky_q <= ovf_sticky_q | ovf_d;
            if (fin_valid) begin
                x_out_q <= sat_res;
                c_out_q <= fin_c;
                s_out_q <= fin_s;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign x_out      = x_out_q;
    assign c_out      = c_out_q;
    assign s_out      = s_out_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = ovf_sticky_q;
    assign p_out      = p_q;

endmodule

// File: tb/tb_internal_cell_pipe.sv
// Scoreboard bench: both latencies (PIPE=1 and PIPE=2) run side by side on the
// same stimulus; hand-computed results are queued at issue time and a negedge
// monitor consumes them whenever out_valid is seen.
module tb_internal_cell_pipe;

    localparam int DW = 16;
    localparam int FW = 8;

    typedef struct packed {
        logic [1:0]        mode;
        logic signed [15:0] c;
        logic signed [15:0] x;
        logic              s;
        logic signed [15:0] ex;
        logic              eovf;
        logic signed [15:0] ep;
    } vec_t;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] c;
        logic              s;
        logic              ovf;
        logic [1:0]        mask;
        int                issue;
    } exp_t;

    typedef struct packed {
        int id;
        int k;
        int act;
        int expv;
    } dchk_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [DW-1:0] c_in = '0;
    logic [DW-1:0] x_in = '0;
    logic          s_in = 1'b0;

    logic          ov[2];
    logic [DW-1:0] co[2];
    logic [DW-1:0] xo[2];
    logic [DW-1:0] po[2];
    logic          so[2];
    logic          of[2];
    logic          st[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        internal_cell_pipe #(
            .DATA_W(DW),
            .FRAC_W(FW),
            .PIPE  (g + 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .mode      (mode),
            .c_in      (c_in),
            .x_in      (x_in),
            .s_in      (s_in),
            .out_valid (ov[g]),
            .c_out     (co[g]),
            .x_out     (xo[g]),
            .s_out     (so[g]),
            .ovf       (of[g]),
            .ovf_sticky(st[g]),
            .p_out     (po[g])
        );
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t          exp_list[$];
    dchk_t         dq[$];
    int            rd[2] = '{0, 0};
    int            checks = 0;
    int            errors = 0;
    logic          armed = 1'b0;
    logic [DW-1:0] last_x[2] = '{16'd0, 16'd0};
    logic [DW-1:0] last_c[2] = '{16'd0, 16'd0};
    logic          last_s[2] = '{1'b0, 1'b0};
    exp_t          mon_e;
    dchk_t         mon_d;
    vec_t          vecs[14];

    function automatic string name_of(input int id);
        case (id)
            0:  return "reset_p_out";
            1:  return "reset_out_valid";
            2:  return "reset_x_out";
            3:  return "reset_ovf_sticky";
            4:  return "p_after_beat";
            5:  return "p_hold_in_gap";
            6:  return "sticky_after_sat";
            7:  return "p_after_reset";
            8:  return "sticky_after_reset";
            9:  return "all_results_seen";
            10: return "x_out";
            11: return "c_out";
            12: return "s_out";
            13: return "ovf";
            14: return "latency";
            15: return "sticky_with_ovf";
            16: return "hold_x_out";
            17: return "hold_c_out";
            18: return "hold_s_out_ovf";
            19: return "unexpected_out_valid";
            default: return "unknown";
        endcase
    endfunction

    function automatic void do_check(input int id, input int k, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s inst PIPE=%0d: got %0d expected %0d", name_of(id), k + 1, act, expv);
        end
    endfunction

    function automatic vec_t mk(input logic [1:0] m, input int c, input int x, input logic s,
                                input int ex, input logic eo, input int ep);
        vec_t v;
        v.mode = m;
        v.c    = 16'(c);
        v.x    = 16'(x);
        v.s    = s;
        v.ex   = 16'(ex);
        v.eovf = eo;
        v.ep   = 16'(ep);
        return v;
    endfunction

    function automatic void push_d(input int id, input int k, input int act, input int expv);
        dchk_t d;
        d.id   = id;
        d.k    = k;
        d.act  = act;
        d.expv = expv;
        dq.push_back(d);
    endfunction

    // Monitor: consume expected results on out_valid, check holding between beats
    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                while (rd[k] < exp_list.size() && !exp_list[rd[k]].mask[k]) rd[k]++;
                if (ov[k] === 1'b1) begin
                    if (rd[k] >= exp_list.size()) begin
                        do_check(19, k, 1, 0);
                    end else begin
                        mon_e = exp_list[rd[k]];
                        rd[k]++;
                        do_check(10, k, int'($signed(xo[k])), int'($signed(mon_e.x)));
                        do_check(11, k, int'($signed(co[k])), int'($signed(mon_e.c)));
                        do_check(12, k, int'(so[k]), int'(mon_e.s));
                        do_check(13, k, int'(of[k]), int'(mon_e.ovf));
                        do_check(14, k, cyc - mon_e.issue, k + 1);
                        if (mon_e.ovf) do_check(15, k, int'(st[k]), 1);
                        last_x[k] = mon_e.x;
                        last_c[k] = mon_e.c;
                        last_s[k] = mon_e.s;
                    end
                end else if (!rst) begin
                    do_check(16, k, int'($signed(xo[k])), int'($signed(last_x[k])));
                    do_check(17, k, int'($signed(co[k])), int'($signed(last_c[k])));
                    do_check(18, k, int'({so[k], of[k]}), int'({last_s[k], 1'b0}));
                end
                if (rst) begin
                    last_x[k] = '0;
                    last_c[k] = '0;
                    last_s[k] = 1'b0;
                end
            end
        end
        while (dq.size() > 0) begin
            mon_d = dq.pop_front();
            do_check(mon_d.id, mon_d.k, mon_d.act, mon_d.expv);
        end
    end

    task automatic beat(input vec_t v, input logic [1:0] mask);
        exp_t r;
        in_valid = 1'b1;
        mode     = v.mode;
        c_in     = v.c;
        x_in     = v.x;
        s_in     = v.s;
        if (mask != 2'b00) begin
            r.x     = v.ex;
            r.c     = v.c;
            r.s     = v.s;
            r.ovf   = v.eovf;
            r.mask  = mask;
            r.issue = cyc;
            exp_list.push_back(r);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) push_d(4, k, int'($signed(po[k])), int'($signed(v.ep)));
    endtask

    // Idle cycle with junk inputs; mode=11 would clear p if the idle beat leaked in
    task automatic gap(input logic signed [15:0] ep);
        in_valid = 1'b0;
        mode     = 2'b11;
        c_in     = 16'h1357;
        x_in     = 16'h2468;
        s_in     = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) push_d(5, k, int'($signed(po[k])), int'(ep));
    endtask

    initial begin
        //            mode   c       x      s   x_out   ovf  p after
        vecs[0]  = mk(2'b10, 5,      512,   1, 0,      0,   512);
        vecs[1]  = mk(2'b00, -128,   256,   1, 0,      0,   512);
        vecs[2]  = mk(2'b01, 256,    768,   1, 1280,   0,   768);
        vecs[3]  = mk(2'b01, 256,    0,     0, 768,    0,   768);
        vecs[4]  = mk(2'b01, -1,     100,   1, 767,    0,   100);   // -100>>>8 = -1
        vecs[5]  = mk(2'b11, 3,      -7,    0, -7,     0,   0);
        vecs[6]  = mk(2'b10, 9,      32767, 0, 0,      0,   32767);
        vecs[7]  = mk(2'b00, 32767,  32767, 0, 32767,  1,   32767);
        vecs[8]  = mk(2'b00, -32768, 32767, 1, -32768, 1,   32767);
        vecs[9]  = mk(2'b00, 0,      -5,    0, -5,     0,   32767);
        vecs[10] = mk(2'b11, -1,     0,     1, 0,      0,   0);
        vecs[11] = mk(2'b10, 1,      77,    1, 0,      0,   77);    // in flight at reset
        vecs[12] = mk(2'b00, 256,    10,    0, 0,      0,   0);     // presented with rst=1
        vecs[13] = mk(2'b00, 256,    10,    0, 10,     0,   0);

        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b0;
        armed = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push_d(0, k, int'(po[k]), 0);
            push_d(1, k, int'(ov[k]), 0);
            push_d(2, k, int'(xo[k]), 0);
            push_d(3, k, int'(st[k]), 0);
        end

        // Beats separated by idle cycles
        for (int i = 0; i < 6; i++) begin
            beat(vecs[i], 2'b11);
            gap(vecs[i].ep);
        end
        // Back-to-back run, each beat depends on the p written by the one before
        for (int i = 6; i < 11; i++) beat(vecs[i], 2'b11);
        repeat (3) gap(vecs[10].ep);
        for (int k = 0; k < 2; k++) push_d(6, k, int'(st[k]), 1);

        // With one cycle of latency this beat emerges before the reset edge; with two it dies
        beat(vecs[11], 2'b01);
        rst      = 1'b1;
        in_valid = 1'b1;
        mode     = vecs[12].mode;
        c_in     = vecs[12].c;
        x_in     = vecs[12].x;
        s_in     = vecs[12].s;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            push_d(7, k, int'(po[k]), 0);
            push_d(8, k, int'(st[k]), 0);
        end
        repeat (3) gap(16'sd0);

        beat(vecs[13], 2'b11);
        repeat (4) gap(16'sd0);

        for (int k = 0; k < 2; k++) push_d(9, k, rd[k], exp_list.size());
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/internal_cell_pipe.md
INTERNAL_CELL_PIPE -- requirements
Module: internal_cell_pipe

Interface
REQ-001 Parameter DATA_W, default 32: signed two's-complement width of c, x and p data paths.
REQ-002 Parameter FRAC_W, default 16: fractional bits of the fixed-point format; legal range 0..DATA_W-1.
REQ-003 Parameter PIPE, default 2: cell latency in cycles; legal values 1 and 2.
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port rst  input  1  synchronous reset, active-high.
REQ-006 Port in_valid  input  1  input beat qualifier.
REQ-007 Port mode  input  2  00 non-pivoting, 01 neighbour-pivoting, 10 shift (load/unload p), 11 clear p.
REQ-008 Port c_in  input  DATA_W  multiplier coefficient from the left neighbour.
REQ-009 Port x_in  input  DATA_W  operand from the upper neighbour.
REQ-010 Port s_in  input  1  pivot-swap flag from the left neighbour.
REQ-011 Port out_valid  output  1  output beat qualifier.
REQ-012 Port c_out, x_out  output  DATA_W  coefficient forwarded right, result forwarded down.
REQ-013 Port s_out  output  1  swap flag forwarded right.
REQ-014 Port ovf  output  1  saturation occurred on the beat qualified by out_valid.
REQ-015 Port ovf_sticky  output  1  saturation has occurred on any beat since reset.
REQ-016 Port p_out  output  DATA_W  current stored element p (observability only).

Function
REQ-017 Effective swap sw = s_in when mode=01, else 0.
REQ-018 Modes 00/01: w1 = sw ? x_in : p; w2 = sw ? p : x_in; p_next = sw ? x_in : p.
REQ-019 Modes 00/01: prod = (c_in * w1) computed at 2*DATA_W bits, arithmetic shift right by FRAC_W (truncation toward minus infinity).
REQ-020 Modes 00/01: result = prod + sign-extended w2, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; ovf = 1 when clamping occurs.
REQ-021 Mode 10: p_next = x_in; result = old p; ovf = 0 (a row of cells forms a load/unload shift chain).
REQ-022 Mode 11: p_next = 0; result = x_in; ovf = 0.
REQ-023 p updates on the clock edge where in_valid=1, independent of PIPE; back-to-back beats always see the p written by the preceding beat (no hazard, no stall).
REQ-024 When in_valid=0: p holds; c_out, x_out, s_out hold their last values; out_valid=0 and ovf=0 after PIPE cycles.
REQ-025 PIPE=1: result, c_in, s_in, in_valid and ovf are registered once; out_valid asserts the cycle after the in_valid beat.
REQ-026 PIPE=2: stage 1 registers the shifted product, w2, c_in, s_in, in_valid and mode-decoded bypass; stage 2 registers the saturated sum; c_out, s_out and out_valid are delayed 2 cycles, aligned with x_out.
REQ-027 s_out equals s_in of the same beat in every mode; c_out equals c_in of the same beat in every mode.
REQ-028 ovf_sticky sets on any cycle where ovf=1 and clears only on reset.
REQ-029 p_out reflects p directly from its register (visible one cycle after the update beat).

Reset
REQ-030 While rst=1 at a clock edge: p, all pipeline registers, c_out, x_out, s_out, out_valid, ovf, ovf_sticky and p_out become 0.
REQ-031 Reset takes priority over in_valid on the same edge; in-flight beats are discarded and never produce out_valid.
REQ-032 The first beat accepted is the one with in_valid=1 on the first edge where rst=0.

Verification (DATA_W=16, FRAC_W=8, both PIPE values)
REQ-033 Shift: mode=10, x_in=512, one beat -> p_out=512, x_out=0 (old p), out_valid after PIPE cycles.
REQ-034 Non-pivot: p=512, mode=00, c_in=-128, x_in=256, s_in=1 -> x_out=0, s_out=1, c_out=-128, p_out stays 512.
REQ-035 Pivot: p=512, mode=01, c_in=256, x_in=768, s_in=1 -> x_out=1280, p_out=768; next beat with s_in=0, c_in=256, x_in=0 -> x_out=768.
REQ-036 Saturation: p=32767, mode=00, c_in=32767, x_in=32767 -> x_out=32767, ovf=1 for one beat, ovf_sticky=1 until reset; same with c_in=-32768 -> x_out=-32768.
REQ-037 Gaps and back-to-back: alternating in_valid=1/0, then four consecutive beats -> out_valid pattern equals in_valid delayed exactly PIPE cycles; outputs hold during gaps.
REQ-038 Reset mid-stream: rst=1 for one cycle while two beats are in flight -> no out_valid follows, all outputs 0, p_out=0, ovf_sticky=0.
